// File: rtl/grf_wb_arbiter_pkg.sv
// Shared types for the GRF write-back arbiter: register/data widths, the
// write request bundle and the long-op FIFO entry.
package grf_wb_arbiter_pkg;

    localparam int unsigned REG_W    = 5;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned NUM_REGS = 32;

    typedef logic [REG_W-1:0]  reg_idx_t;
    typedef logic [DATA_W-1:0] data_t;

    typedef struct packed {
        logic     we;
        reg_idx_t a3;
        data_t    wd;
        data_t    pc;
    } wb_req_t;

    typedef struct packed {
        reg_idx_t a3;
        data_t    wd;
        data_t    pc;
    } lo_entry_t;

    // $0 is hard-wired, so it can never be a pending destination.
    function automatic logic is_pending(input reg_idx_t idx, input logic [NUM_REGS-1:0] pend);
        return (idx != '0) && pend[idx];
    endfunction

endpackage

// File: rtl/grf_wb_arbiter_wb_fifo.sv
// Small synchronous FIFO holding long-op results until a free GRF write slot.
// The head is combinational so it can be written in the same cycle it pops.
module grf_wb_arbiter_wb_fifo
    import grf_wb_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic      clk,
    input  logic      RE,
    input  logic      push,
    input  logic      pop,
    input  lo_entry_t din,
    output lo_entry_t head,
    output logic      full,
    output logic      empty
);

    lo_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic [PTR_W:0]   count_d;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + (PTR_W+1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (PTR_W+1)'(1);
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (RE) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !RE) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign full  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/grf_wb_arbiter.sv
// Arbitrates the single GRF write port between the W stage and buffered
// long-op results, and tracks in-flight long-op destinations for hazards.
module grf_wb_arbiter
    import grf_wb_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH        = 2,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned PTR_W        = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              RE,
    input  logic              wb_we,
    input  logic [REG_W-1:0]  wb_a3,
    input  logic [DATA_W-1:0] wb_wd,
    input  logic [DATA_W-1:0] wb_pc,
    input  logic              lo_valid,
    input  logic [REG_W-1:0]  lo_a3,
    input  logic [DATA_W-1:0] lo_wd,
    input  logic [DATA_W-1:0] lo_pc,
    output logic              lo_ready,
    input  logic              iss_valid,
    input  logic [REG_W-1:0]  iss_a3,
    input  logic [REG_W-1:0]  chk_rs,
    input  logic [REG_W-1:0]  chk_rt,
    input  logic [REG_W-1:0]  chk_rd,
    output logic              busy,
    output logic              stall_req,
    output logic              grf_we,
    output logic [REG_W-1:0]  grf_a3,
    output logic [DATA_W-1:0] grf_wd,
    output logic [DATA_W-1:0] grf_pc
);

    localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);

    wb_req_t   pipe_req;
    wb_req_t   grf_req;
    lo_entry_t lo_in;
    lo_entry_t fifo_head;
    logic      fifo_full;
    logic      fifo_empty;
    logic      slot_free;
    logic      push;
    logic      pop;
    logic      head_waiting;

    logic [StarveW-1:0]  starve_q, starve_d;
    logic                stall_q, stall_d;
    logic [NUM_REGS-1:0] pending_q, pending_d;

    assign pipe_req = '{we: wb_we, a3: wb_a3, wd: wb_wd, pc: wb_pc};
    assign lo_in    = '{a3: lo_a3, wd: lo_wd, pc: lo_pc};

    // A write to $0 is architecturally a no-op, so it leaves the port free.
    assign slot_free    = !wb_we || (wb_a3 == '0);
    assign pop          = !RE && slot_free && !fifo_empty;
    assign lo_ready     = !RE && (!fifo_full || pop);
    assign push         = lo_valid && lo_ready && (lo_a3 != '0);
    assign head_waiting = !fifo_empty && !pop;

    grf_wb_arbiter_wb_fifo #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk   (clk),
        .RE    (RE),
        .push  (push),
        .pop   (pop),
        .din   (lo_in),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        grf_req    = pipe_req;
        grf_req.we = 1'b0;
        if (!RE) begin
            if (!slot_free) begin
                grf_req = pipe_req;
            end else if (!fifo_empty) begin
                grf_req = '{we: 1'b1, a3: fifo_head.a3, wd: fifo_head.wd, pc: fifo_head.pc};
            end
        end
    end

    assign grf_we = grf_req.we;
    assign grf_a3 = grf_req.a3;
    assign grf_wd = grf_req.wd;
    assign grf_pc = grf_req.pc;

    always_comb begin
        starve_d = starve_q;
        if (!head_waiting) begin
            starve_d = '0;
        end else if (starve_q != StarveW'(STARVE_LIMIT)) begin
            starve_d = starve_q + StarveW'(1);
        end
        stall_d = head_waiting && (starve_q >= StarveW'(STARVE_LIMIT - 1));
    end

    // Issue is applied after the pop clear so a re-issue of the same register wins.
    always_comb begin
        pending_d = pending_q;
        if (pop) begin
            pending_d[fifo_head.a3] = 1'b0;
        end
        if (iss_valid && (iss_a3 != '0)) begin
            pending_d[iss_a3] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (RE) begin
            starve_q  <= '0;
            stall_q   <= 1'b0;
            pending_q <= '0;
        end else begin
            starve_q  <= starve_d;
            stall_q   <= stall_d;
            pending_q <= pending_d;
        end
    end

    assign stall_req = stall_q;
    assign busy      = !RE && (is_pending(chk_rs, pending_q) ||
                               is_pending(chk_rt, pending_q) ||
                               is_pending(chk_rd, pending_q));

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Self-checking bench for grf_wb_arbiter: a reference queue/pending model
// predicts every GRF write and status output, plus directed boundary checks.
module tb_grf_wb_arbiter;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned LIMIT = 4;

    logic        clk = 1'b0;
    logic        RE;
    logic        wb_we;
    logic [4:0]  wb_a3;
    logic [31:0] wb_wd, wb_pc;
    logic        lo_valid;
    logic [4:0]  lo_a3;
    logic [31:0] lo_wd, lo_pc;
    logic        lo_ready;
    logic        iss_valid;
    logic [4:0]  iss_a3, chk_rs, chk_rt, chk_rd;
    logic        busy, stall_req;
    logic        grf_we;
    logic [4:0]  grf_a3;
    logic [31:0] grf_wd, grf_pc;

    always #5 clk = ~clk;

    grf_wb_arbiter #(
        .DEPTH        (DEPTH),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk       (clk),
        .RE        (RE),
        .wb_we     (wb_we),
        .wb_a3     (wb_a3),
        .wb_wd     (wb_wd),
        .wb_pc     (wb_pc),
        .lo_valid  (lo_valid),
        .lo_a3     (lo_a3),
        .lo_wd     (lo_wd),
        .lo_pc     (lo_pc),
        .lo_ready  (lo_ready),
        .iss_valid (iss_valid),
        .iss_a3    (iss_a3),
        .chk_rs    (chk_rs),
        .chk_rt    (chk_rt),
        .chk_rd    (chk_rd),
        .busy      (busy),
        .stall_req (stall_req),
        .grf_we    (grf_we),
        .grf_a3    (grf_a3),
        .grf_wd    (grf_wd),
        .grf_pc    (grf_pc)
    );

    typedef struct {
        logic [4:0]  a3;
        logic [31:0] wd;
        logic [31:0] pc;
    } ent_t;

    int    n_tests = 0;
    int    n_fail  = 0;
    string phase   = "init";

    // Reference model state.
    ent_t        mdl_q[$];
    logic [31:0] mdl_pend  = '0;
    int          mdl_starve = 0;
    logic        mdl_stall = 1'b0;

    // Outputs as sampled in the most recent tick.
    logic        s_grf_we, s_lo_ready, s_busy, s_stall;
    logic [4:0]  s_grf_a3;
    logic [31:0] s_grf_wd, s_grf_pc;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        wb_we = 1'b0; wb_a3 = '0; wb_wd = '0; wb_pc = '0;
        lo_valid = 1'b0; lo_a3 = '0; lo_wd = '0; lo_pc = '0;
        iss_valid = 1'b0; iss_a3 = '0;
        chk_rs = '0; chk_rt = '0; chk_rd = '0;
    endtask

    task automatic set_lo(input logic [4:0] a3, input logic [31:0] wd, input logic [31:0] pc);
        lo_valid = 1'b1; lo_a3 = a3; lo_wd = wd; lo_pc = pc;
    endtask

    task automatic set_wb(input logic [4:0] a3);
        wb_we = 1'b1; wb_a3 = a3; wb_wd = {27'h0, a3} ^ 32'hC0DE_0000; wb_pc = 32'h0000_1000;
    endtask

    // One clock: compare at negedge against the model, then advance the model.
    task automatic tick();
        logic        exp_we, exp_ready, exp_busy, pop_m, waiting;
        logic [4:0]  ea3;
        logic [31:0] ewd, epc;
        ent_t        e;
        @(negedge clk);
        pop_m = 1'b0; exp_we = 1'b0; ea3 = '0; ewd = '0; epc = '0;
        if (RE) begin
            exp_we = 1'b0;
        end else if (wb_we && wb_a3 != 5'd0) begin
            exp_we = 1'b1; ea3 = wb_a3; ewd = wb_wd; epc = wb_pc;
        end else if (mdl_q.size() > 0) begin
            exp_we = 1'b1; ea3 = mdl_q[0].a3; ewd = mdl_q[0].wd; epc = mdl_q[0].pc;
            pop_m = 1'b1;
        end
        exp_ready = !RE && (mdl_q.size() < DEPTH || pop_m);
        exp_busy  = !RE && ((chk_rs != 5'd0 && mdl_pend[chk_rs]) ||
                            (chk_rt != 5'd0 && mdl_pend[chk_rt]) ||
                            (chk_rd != 5'd0 && mdl_pend[chk_rd]));
        check_eq($sformatf("%s.grf_we", phase), grf_we, exp_we);
        if (exp_we) begin
            check_eq($sformatf("%s.grf_a3", phase), grf_a3, ea3);
            check_eq($sformatf("%s.grf_wd", phase), grf_wd, ewd);
            check_eq($sformatf("%s.grf_pc", phase), grf_pc, epc);
        end
        check_eq($sformatf("%s.lo_ready", phase), lo_ready, exp_ready);
        check_eq($sformatf("%s.busy", phase), busy, exp_busy);
        check_eq($sformatf("%s.stall_req", phase), stall_req, mdl_stall);
        s_grf_we = grf_we; s_grf_a3 = grf_a3; s_grf_wd = grf_wd; s_grf_pc = grf_pc;
        s_lo_ready = lo_ready; s_busy = busy; s_stall = stall_req;
        @(posedge clk);
        if (RE) begin
            mdl_q.delete();
            mdl_pend = '0; mdl_starve = 0; mdl_stall = 1'b0;
        end else begin
            waiting    = (mdl_q.size() > 0) && !pop_m;
            mdl_stall  = waiting && (mdl_starve >= LIMIT - 1);
            mdl_starve = waiting ? ((mdl_starve < LIMIT) ? mdl_starve + 1 : LIMIT) : 0;
            if (pop_m) begin
                e = mdl_q.pop_front();
                mdl_pend[e.a3] = 1'b0;
            end
            if (lo_valid && exp_ready && lo_a3 != 5'd0) begin
                e.a3 = lo_a3; e.wd = lo_wd; e.pc = lo_pc;
                mdl_q.push_back(e);
            end
            if (iss_valid && iss_a3 != 5'd0) mdl_pend[iss_a3] = 1'b1;
        end
        #1;
    endtask

    initial begin
        int n;
        RE = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        RE = 1'b0;

        // Reset with a queued result and a pending register.
        phase = "t1_reset";
        set_wb(5'd2); iss_valid = 1'b1; iss_a3 = 5'd7; set_lo(5'd5, 32'h55, 32'h500);
        tick();
        idle(); RE = 1'b1; set_lo(5'd5, 32'h56, 32'h504); chk_rs = 5'd7;
        tick();
        check_eq("t1_grf_we_in_reset", s_grf_we, 1'b0);
        check_eq("t1_lo_ready_in_reset", s_lo_ready, 1'b0);
        check_eq("t1_busy_in_reset", s_busy, 1'b0);
        RE = 1'b0; idle(); chk_rs = 5'd7;
        tick();
        check_eq("t1_busy_after", s_busy, 1'b0);
        check_eq("t1_fifo_empty", s_grf_we, 1'b0);

        // Idle slot drains a long-op result one cycle after it arrives.
        phase = "t2_drain";
        idle(); iss_valid = 1'b1; iss_a3 = 5'd8; set_lo(5'd8, 32'h1234, 32'h3000);
        tick();
        idle(); chk_rs = 5'd8;
        tick();
        check_eq("t2_we", s_grf_we, 1'b1);
        check_eq("t2_a3", s_grf_a3, 5'd8);
        check_eq("t2_wd", s_grf_wd, 32'h1234);
        check_eq("t2_pc", s_grf_pc, 32'h3000);
        check_eq("t2_busy_before_pop", s_busy, 1'b1);
        idle(); chk_rs = 5'd8;
        tick();
        check_eq("t2_busy_cleared", s_busy, 1'b0);

        // Pipeline priority and starvation stall.
        phase = "t3_starve";
        idle(); set_wb(5'd3); iss_valid = 1'b1; iss_a3 = 5'd10; set_lo(5'd10, 32'hAAAA, 32'h4000);
        tick();
        lo_valid = 1'b0; iss_valid = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
            check_eq("t3_pipe_a3", s_grf_a3, 5'd3);
        end while (!s_stall && n < 10);
        check_eq("t3_stall_cycle", n, 5);
        idle();
        tick();
        check_eq("t3_head_written", s_grf_a3, 5'd10);
        check_eq("t3_stall_during_pop", s_stall, 1'b1);
        tick();
        check_eq("t3_stall_fall", s_stall, 1'b0);

        // Full FIFO: back-pressure, then simultaneous pop and push.
        phase = "t4_full";
        idle(); set_wb(5'd3); set_lo(5'd11, 32'hB11, 32'h5000);
        tick();
        set_lo(5'd12, 32'hB12, 32'h5004);
        tick();
        set_lo(5'd13, 32'hB13, 32'h5008);
        tick();
        check_eq("t4_full_not_ready", s_lo_ready, 1'b0);
        wb_we = 1'b0; wb_a3 = '0;
        tick();
        check_eq("t4_ready_on_pop", s_lo_ready, 1'b1);
        check_eq("t4_pop_a3", s_grf_a3, 5'd11);
        lo_valid = 1'b0; set_wb(5'd3);
        tick();
        check_eq("t4_still_full", s_lo_ready, 1'b0);
        idle();
        repeat (3) tick();
        check_eq("t4_drained", s_grf_we, 1'b0);

        // $0 handling on both sides.
        phase = "t5_zero";
        idle(); set_wb(5'd3); iss_valid = 1'b1; iss_a3 = 5'd15; set_lo(5'd14, 32'hE14, 32'h6000);
        tick();
        idle(); wb_we = 1'b1; wb_a3 = 5'd0; wb_wd = 32'hBAD; set_lo(5'd0, 32'hDEAD, 32'h6004);
        tick();
        check_eq("t5_drain_on_a3_0", s_grf_a3, 5'd14);
        check_eq("t5_zero_push_ready", s_lo_ready, 1'b1);
        idle(); chk_rs = 5'd15;
        repeat (2) tick();
        check_eq("t5_zero_not_written", s_grf_we, 1'b0);
        check_eq("t5_pending_kept", s_busy, 1'b1);

        // Issue and pop of the same register in one cycle.
        phase = "t6_collide";
        idle(); set_wb(5'd3); set_lo(5'd9, 32'h909, 32'h7000);
        tick();
        idle(); iss_valid = 1'b1; iss_a3 = 5'd9;
        tick();
        check_eq("t6_pop_a3", s_grf_a3, 5'd9);
        idle(); chk_rs = 5'd9;
        tick();
        check_eq("t6_set_wins", s_busy, 1'b1);

        // Random traffic against the model.
        phase = "rand";
        for (int i = 0; i < 400; i++) begin
            RE        = ($urandom_range(0, 63) == 0);
            wb_we     = 1'($urandom_range(0, 1));
            wb_a3     = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            wb_wd     = $urandom();
            wb_pc     = $urandom();
            lo_valid  = 1'($urandom_range(0, 1));
            lo_a3     = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            lo_wd     = $urandom();
            lo_pc     = $urandom();
            iss_valid = 1'($urandom_range(0, 1));
            iss_a3    = 5'($urandom_range(0, 31));
            chk_rs    = 5'($urandom_range(0, 31));
            chk_rt    = 5'($urandom_range(0, 31));
            chk_rd    = 5'($urandom_range(0, 31));
            tick();
        end

        phase = "final_drain";
        RE = 1'b0; idle();
        n = 0;
        while (mdl_q.size() > 0 && n < 20) begin
            tick();
            n++;
        end
        check_eq("final_drain_done", mdl_q.size(), 0);
        tick();
        check_eq("final_idle", s_grf_we, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
